switch_input_conditioner: RTL

Two-channel synchronizer and debouncer for raw board slide switches and push buttons. Its clean, stable levels drive the i_0/i_1 inputs of the basic gate modules (nand_gate, and_gate, etc.), so that gate outputs on LEDs never flicker from contact bounce. Each channel also produces single-cycle rise and fall pulses for downstream counters and toggles.

---
 rtl/sw_cond_pkg.sv | 19 +
 rtl/debounce_channel.sv | 141 ++++++++++++++
 rtl/switch_input_conditioner.sv | 53 +++++
 3 files changed

// File: rtl/sw_cond_pkg.sv
// Shared definitions for the switch input conditioner.
//
// Contents:
//   sw_state_e          - per-channel debounce state, 2 bits
//   MIN_STABLE_CYCLES   - smallest legal debounce window
//   DEFAULT_SYNC_STAGES - default synchronizer depth
package sw_cond_pkg;

    typedef enum logic [1:0] {
        STABLE_0 = 2'b00,
        PEND_1   = 2'b01,
        STABLE_1 = 2'b10,
        PEND_0   = 2'b11
    } sw_state_e;

    localparam int unsigned MIN_STABLE_CYCLES   = 2;
    localparam int unsigned DEFAULT_SYNC_STAGES = 2;

endpackage : sw_cond_pkg

// File: rtl/debounce_channel.sv
// One switch channel: synchronizer chain, debounce counter, state machine
// and registered edge pulses.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// STABLE_0 | output low, synchronized input low
// PEND_1   | output low, input high; counting samples toward a rise
// STABLE_1 | output high, synchronized input high
// PEND_0   | output high, input low; counting samples toward a fall
//
// Ports:
//   clk_i   - system clock, rising edge
//   rst_ni  - asynchronous active-low reset
//   sw_i    - raw asynchronous switch input
//   level_o - debounced level
//   rise_o  - one-cycle pulse, first cycle level_o is 1
//   fall_o  - one-cycle pulse, first cycle level_o is 0
module debounce_channel
    import sw_cond_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = DEFAULT_SYNC_STAGES,
    parameter int unsigned STABLE_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("debounce_channel: SYNC_STAGES must be 2..4");
    end
    if (STABLE_CYCLES < MIN_STABLE_CYCLES) begin : g_bad_stable
        $error("debounce_channel: STABLE_CYCLES below minimum");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    sw_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sw_i};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= STABLE_0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // A sample at the old level in a PEND state drops straight back to the
    // stable state with the count cleared, so a bounce never earns credit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            STABLE_0: begin
                if (s) begin
                    state_d = PEND_1;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            PEND_1: begin
                if (!s) begin
                    state_d = STABLE_0;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_1;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            STABLE_1: begin
                if (!s) begin
                    state_d = PEND_0;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            PEND_0: begin
                if (s) begin
                    state_d = STABLE_1;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_0;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_0;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule : debounce_channel

// File: rtl/switch_input_conditioner.sv
// Two independent switch/button conditioners producing clean levels for the
// gate inputs plus single-cycle rise/fall pulses.
//
// Ports:
//   i_clk    - system clock, rising edge
//   i_rst_n  - asynchronous active-low reset
//   i_sw_0/1 - raw asynchronous switch inputs
//   o_0/1    - debounced levels
//   o_rise_x - one-cycle pulse when o_x goes 0->1
//   o_fall_x - one-cycle pulse when o_x goes 1->0
module switch_input_conditioner
    import sw_cond_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = DEFAULT_SYNC_STAGES,
    parameter int unsigned STABLE_CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sw_0,
    input  logic i_sw_1,
    output logic o_0,
    output logic o_1,
    output logic o_rise_0,
    output logic o_fall_0,
    output logic o_rise_1,
    output logic o_fall_1
);

    debounce_channel #(
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_ch0 (
        .clk_i  (i_clk),
        .rst_ni (i_rst_n),
        .sw_i   (i_sw_0),
        .level_o(o_0),
        .rise_o (o_rise_0),
        .fall_o (o_fall_0)
    );

    debounce_channel #(
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_ch1 (
        .clk_i  (i_clk),
        .rst_ni (i_rst_n),
        .sw_i   (i_sw_1),
        .level_o(o_1),
        .rise_o (o_rise_1),
        .fall_o (o_fall_1)
    );

endmodule : switch_input_conditioner
